// File: rtl/alu_dmem_unit.sv
// Single-cycle datapath slice: ALU control decode, combinational ALU and a
// word-addressed data memory with combinational read and clocked write.
module alu_dmem_unit #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_result,
    output logic        zero,
    input  logic [31:0] mem_addr,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] word_idx;
    logic          unused_addr_bits;

    always_comb begin
        alu_ctrl = CTRL_ADD;
        case (alu_op)
            2'b00: alu_ctrl = CTRL_ADD;
            2'b01: alu_ctrl = CTRL_SUB;
            2'b11: alu_ctrl = CTRL_AND;
            default: begin
                case (funct)
                    6'b100000: alu_ctrl = CTRL_ADD;
                    6'b100010: alu_ctrl = CTRL_SUB;
                    6'b100100: alu_ctrl = CTRL_AND;
                    6'b100101: alu_ctrl = CTRL_OR;
                    6'b100111: alu_ctrl = CTRL_NOR;
                    6'b101010: alu_ctrl = CTRL_SLT;
                    default:   alu_ctrl = CTRL_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            CTRL_AND: alu_result = alu_a & alu_b;
            CTRL_OR:  alu_result = alu_a | alu_b;
            CTRL_ADD: alu_result = alu_a + alu_b;
            CTRL_SUB: alu_result = alu_a - alu_b;
            CTRL_SLT: alu_result = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            CTRL_NOR: alu_result = ~(alu_a | alu_b);
            default:  alu_result = 32'h0;
        endcase
    end

    assign zero = (alu_result == 32'h0);

    // Byte offset and high address bits are dropped, so addresses alias freely.
    assign word_idx         = mem_addr[AW+1:2];
    assign unused_addr_bits = ^{mem_addr[31:AW+2], mem_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (mem_write) begin
            mem_q[word_idx] <= mem_wdata;
        end
    end

    assign mem_rdata = (mem_read && rst_n) ? mem_q[word_idx] : 32'h0;

endmodule

// File: tb/tb_alu_dmem_unit.sv
// Self-checking bench for alu_dmem_unit: ALU vectors, random ALU traffic,
// memory read/write, aliasing and asynchronous reset behaviour.
module tb_alu_dmem_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_addr;
    logic        mem_write, mem_read;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [256];
    logic [31:0] exp_v;
    int          n_cmp  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    alu_dmem_unit #(.DEPTH(256), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_op(alu_op), .funct(funct), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_read(mem_read),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Reference: result from operation meaning, not from the control code.
    function automatic logic [31:0] model_alu(input logic [1:0] op, input logic [5:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a & b;
        if (f == 6'h22) return a - b;
        if (f == 6'h24) return a & b;
        if (f == 6'h25) return a | b;
        if (f == 6'h27) return ~(a | b);
        if (f == 6'h2a) return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        return a + b;
    endfunction

    function automatic logic [3:0] model_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0000;
        if (f == 6'h22) return 4'b0110;
        if (f == 6'h24) return 4'b0000;
        if (f == 6'h25) return 4'b0001;
        if (f == 6'h27) return 4'b1100;
        if (f == 6'h2a) return 4'b0111;
        return 4'b0010;
    endfunction

    task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        mem_addr  = addr;
        mem_wdata = data;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        if (rst_n) ref_mem[addr[9:2]] = data;
    endtask

    task automatic mem_rd_check(input logic [31:0] addr, input string name);
        mem_addr = addr;
        mem_read = 1'b1;
        exp_q.push_back(ref_mem[addr[9:2]]);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mem_rdata !== exp_v) begin
            n_fail++;
            $display("FAIL %s: addr=%h got=%h expected=%h", name, addr, mem_rdata, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_op = 2'b00; funct = 6'h0; alu_a = 32'd3; alu_b = 32'd4;
        mem_addr = 32'h0; mem_write = 1'b0; mem_read = 1'b1; mem_wdata = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        #3;
        mem_rd_check(32'h0, "reset_rdata0");
        mem_rd_check(32'h3FC, "reset_rdata255");
        exp_q.push_back(32'd7);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (alu_result !== exp_v || zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alu: got=%h/%b expected=%h/0", alu_result, zero, exp_v);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_vectors();
        logic [1:0]  op_t [6] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00};
        logic [5:0]  f_t  [6] = '{6'h22, 6'h2a, 6'h2a, 6'h00, 6'h27, 6'h3f};
        logic [31:0] a_t  [6] = '{32'd5, 32'hFFFFFFFF, 32'd1, 32'h1234, 32'h0, 32'hFFFFFFFF};
        logic [31:0] b_t  [6] = '{32'd7, 32'd1, 32'hFFFFFFFF, 32'h1234, 32'h0, 32'd1};
        logic [31:0] r_t  [6] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0};
        logic [3:0]  c_t  [6] = '{4'b0110, 4'b0111, 4'b0111, 4'b0110, 4'b1100, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            alu_op = op_t[i]; funct = f_t[i]; alu_a = a_t[i]; alu_b = b_t[i];
            exp_q.push_back(r_t[i]);
            #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (alu_result !== exp_v || alu_ctrl !== c_t[i] || zero !== (r_t[i] == 32'h0)) begin
                n_fail++;
                $display("FAIL alu_vec%0d: got res=%h ctrl=%b zero=%b expected res=%h ctrl=%b",
                         i, alu_result, alu_ctrl, zero, exp_v, c_t[i]);
            end
        end
    endtask

    task automatic test_alu_random();
        logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
        int unsigned sel;
        for (int i = 0; i < 60; i++) begin
            alu_op = 2'($urandom_range(0, 3));
            sel    = $urandom_range(0, 6);
            funct  = (sel == 6) ? 6'($urandom_range(0, 63)) : fl[sel];
            alu_a  = $urandom();
            alu_b  = ($urandom_range(0, 3) == 0) ? alu_a : $urandom();
            exp_q.push_back(model_alu(alu_op, funct, alu_a, alu_b));
            #1;
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (alu_result !== exp_v || zero !== (exp_v == 32'h0) ||
                alu_ctrl !== model_ctrl(alu_op, funct)) begin
                n_fail++;
                $display("FAIL alu_rand op=%b f=%h a=%h b=%h: got res=%h ctrl=%b zero=%b expected res=%h ctrl=%b",
                         alu_op, funct, alu_a, alu_b, alu_result, alu_ctrl, zero, exp_v,
                         model_ctrl(alu_op, funct));
            end
        end
    endtask

    task automatic test_mem_basic();
        mem_read = 1'b0;
        mem_wr(32'd4, 32'hDEADBEEF);
        mem_rd_check(32'd7, "rd_word1_offset");
        mem_read = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        exp_v = exp_q.pop_front();
        n_cmp++;
        if (mem_rdata !== exp_v) begin
            n_fail++;
            $display("FAIL rd_disabled: got=%h expected=%h", mem_rdata, exp_v);
        end
        mem_wr(32'd1024, 32'h55);
        mem_rd_check(32'd0, "alias_1024_to_0");
        mem_rd_check(32'd1028, "alias_1028_to_4");
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        mem_addr = 32'd40; mem_read = 1'b1; mem_write = 1'b1; mem_wdata = 32'hCAFE0001;
        mem_rd_check(32'd40, "rw_old_value");
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        ref_mem[10] = 32'hCAFE0001;
        mem_rd_check(32'd40, "rw_new_value");
    endtask

    task automatic test_reset_mid();
        mem_wr(32'd32, 32'hA5);
        mem_rd_check(32'd32, "pre_reset_word8");
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        mem_read = 1'b0;
        #1;
        rst_n = 1'b1;
        mem_rd_check(32'd32, "async_clear_word8");
        mem_rd_check(32'd4, "async_clear_word1");
        rst_n = 1'b0;
        mem_wr(32'd32, 32'h77);
        #2;
        rst_n = 1'b1;
        mem_rd_check(32'd32, "write_in_reset_ignored");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d;
        for (int i = 0; i < 30; i++) begin
            a = {22'($urandom()), 10'($urandom_range(0, 1023))};
            d = $urandom();
            mem_read = 1'b0;
            mem_wr(a, d);
            mem_rd_check({22'($urandom()), 10'($urandom_range(0, 1023))}, "b2b_rand_read");
            mem_rd_check(a, "b2b_written");
        end
    endtask

    initial begin
        test_reset();
        test_alu_vectors();
        test_alu_random();
        test_mem_basic();
        test_same_cycle();
        test_reset_mid();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL queue_drain: got=%0d leftover expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
